// File: rtl/fpdiv.sv
// fpdiv: iterative IEEE-754 single-precision divider (a / b).
// Restoring division yields one quotient bit per cycle; the result is
// rounded to nearest-even. Subnormal operands are treated as signed zero.
// Ports:
//   clk    - clock, rising-edge active
//   rst    - asynchronous active-high reset
//   valid  - start request; a and b are sampled on the same edge
//   a, b   - dividend and divisor
//   result - quotient, held until the next completion
//   fex    - {invalid, divide_by_zero, overflow}, held with result
//   done   - one-cycle completion pulse
//   busy   - high while a division is in flight
module fpdiv #(
    parameter int DWIDTH = 32,
    parameter int EWIDTH = 8,
    parameter int MWIDTH = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic [DWIDTH-1:0] result,
    output logic [2:0]        fex,
    output logic              done,
    output logic              busy
);

    localparam int QW   = MWIDTH + 3;            // quotient bits produced
    localparam int SW   = EWIDTH + 2;            // signed exponent width
    localparam int CW   = $clog2(QW);            // iteration counter width
    localparam int BIAS = (1 << (EWIDTH - 1)) - 1;
    localparam int EMAX = (1 << EWIDTH) - 1;

    localparam logic [DWIDTH-1:0] QNAN =
        {1'b0, {EWIDTH{1'b1}}, 1'b1, {(MWIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIV,
        S_ROUND,
        S_FINISH
    } state_t;

    state_t state, state_nx;

    logic [DWIDTH-1:0] opa, opb;
    logic [MWIDTH+1:0] rem;
    logic [MWIDTH:0]   dvsr;
    logic [QW-1:0]     quo;
    logic [CW-1:0]     count;
    logic [SW-1:0]     exp_base;

    // Operand fields
    logic              sa, sb, sign_q;
    logic [EWIDTH-1:0] ea, eb;
    logic [MWIDTH-1:0] ma, mb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;

    assign sa     = opa[DWIDTH-1];
    assign sb     = opb[DWIDTH-1];
    assign ea     = opa[DWIDTH-2 -: EWIDTH];
    assign eb     = opb[DWIDTH-2 -: EWIDTH];
    assign ma     = opa[MWIDTH-1:0];
    assign mb     = opb[MWIDTH-1:0];
    assign sign_q = sa ^ sb;

    assign a_nan  = (ea == '1) && (ma != '0);
    assign b_nan  = (eb == '1) && (mb != '0);
    assign a_inf  = (ea == '1) && (ma == '0);
    assign b_inf  = (eb == '1) && (mb == '0);
    // Zero exponent covers subnormals as well: they flush to signed zero.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    // Special-operand result, priority ordered
    logic [DWIDTH-1:0] sp_res;
    logic [2:0]        sp_fex;

    always_comb begin
        sp_res = {sign_q, {(DWIDTH-1){1'b0}}};
        sp_fex = 3'b000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_res = QNAN;
            sp_fex = 3'b100;
        end else if (b_zero && !a_inf) begin
            sp_res = {sign_q, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
            sp_fex = 3'b010;
        end else if (a_inf) begin
            sp_res = {sign_q, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
        end
    end

    // One restoring-division step. When the subtraction succeeds the
    // difference is below the divisor, so it fits in MWIDTH+1 bits.
    logic            ge;
    logic [MWIDTH:0] diff, rem_nx;

    always_comb begin
        ge     = rem >= {1'b0, dvsr};
        diff   = rem[MWIDTH:0] - dvsr;
        rem_nx = ge ? diff : rem[MWIDTH:0];
    end

    // Normalise, round to nearest-even, range check and pack
    logic [MWIDTH-1:0] mant;
    logic              guard, rbit, sticky, inc;
    logic [MWIDTH:0]   mant_r;
    logic [SW-1:0]     exp_r;
    logic [DWIDTH-1:0] rnd_res;
    logic [2:0]        rnd_fex;

    always_comb begin
        if (quo[QW-1]) begin
            mant  = quo[QW-2:2];
            guard = quo[1];
            rbit  = quo[0];
        end else begin
            mant  = quo[QW-3:1];
            guard = quo[0];
            rbit  = 1'b0;
        end
        sticky = (rem != '0) | rbit;
        inc    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {{MWIDTH{1'b0}}, inc};
        // Rounding carry-out leaves mant_r[MWIDTH-1:0] at zero already.
        exp_r  = exp_base - {{(SW-1){1'b0}}, ~quo[QW-1]}
                          + {{(SW-1){1'b0}}, mant_r[MWIDTH]};
        rnd_fex = 3'b000;
        if (!exp_r[SW-1] && (exp_r >= SW'(EMAX))) begin
            rnd_res = {sign_q, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
            rnd_fex = 3'b001;
        end else if (exp_r[SW-1] || (exp_r == '0)) begin
            rnd_res = {sign_q, {(DWIDTH-1){1'b0}}};
        end else begin
            rnd_res = {sign_q, exp_r[EWIDTH-1:0], mant_r[MWIDTH-1:0]};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (valid) state_nx = S_UNPACK;
            S_UNPACK: state_nx = special ? S_FINISH : S_DIV;
            S_DIV:    if (count == CW'(QW-1)) state_nx = S_ROUND;
            S_ROUND:  state_nx = S_IDLE;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Datapath and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa      <= '0;
            opb      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            quo      <= '0;
            count    <= '0;
            exp_base <= '0;
            result   <= '0;
            fex      <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        opa <= a;
                        opb <= b;
                    end
                end
                S_UNPACK: begin
                    rem      <= {1'b0, 1'b1, ma};
                    dvsr     <= {1'b1, mb};
                    quo      <= '0;
                    count    <= '0;
                    exp_base <= {2'b00, ea} - {2'b00, eb} + SW'(BIAS);
                end
                S_DIV: begin
                    rem   <= {rem_nx, 1'b0};
                    quo   <= {quo[QW-2:0], ge};
                    count <= count + 1'b1;
                end
                S_ROUND: begin
                    result <= rnd_res;
                    fex    <= rnd_fex;
                    done   <= 1'b1;
                end
                S_FINISH: begin
                    result <= sp_res;
                    fex    <= sp_fex;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpdiv.sv
// tb_fpdiv: self-checking bench for fpdiv. Accepted requests are queued
// with their accept edge; a monitor compares every completion against an
// exact-integer model of the division and checks handshake timing.
module tb_fpdiv;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] a, b;
    logic [31:0] result;
    logic [2:0]  fex;
    logic        done;
    logic        busy;

    fpdiv #(.DWIDTH(32), .EWIDTH(8), .MWIDTH(23)) dut (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .a      (a),
        .b      (b),
        .result (result),
        .fex    (fex),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op_a;
        logic [31:0] op_b;
        int          acc;
    } req_t;

    req_t        pend[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_done = 0;
    logic        prev_done = 1'b0;
    logic [31:0] last_result = '0;
    logic [2:0]  last_fex = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer quotient of the significands, then the
    // normalise / round-to-nearest-even / range rules applied arithmetically.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [2:0] f,
                                  output int lat);
        int              ex, ey, e;
        longint unsigned mx, my, num, den, q, rm, mant;
        bit              s, xnan, ynan, xinf, yinf, xzero, yzero, g, rb, st;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = longint'(x[22:0]);
        my = longint'(y[22:0]);
        s  = x[31] ^ y[31];
        xnan  = (ex == 255) && (mx != 0);
        ynan  = (ey == 255) && (my != 0);
        xinf  = (ex == 255) && (mx == 0);
        yinf  = (ey == 255) && (my == 0);
        xzero = (ex == 0);
        yzero = (ey == 0);
        lat = 2;
        f   = 3'b000;
        r   = {s, 31'h0};
        if (xnan || ynan || (xzero && yzero) || (xinf && yinf)) begin
            r = 32'h7FC00000;
            f = 3'b100;
        end else if (yzero && !xinf) begin
            r = {s, 8'hFF, 23'h0};
            f = 3'b010;
        end else if (xinf) begin
            r = {s, 8'hFF, 23'h0};
        end else if (xzero || yinf) begin
            r = {s, 31'h0};
        end else begin
            lat = 28;
            num = (mx | 64'h800000) << 25;
            den = my | 64'h800000;
            q   = num / den;
            rm  = num % den;
            if (q >= (64'd1 << 25)) begin
                mant = (q >> 2) & 64'h7FFFFF;
                g    = q[1];
                rb   = q[0];
                e    = ex - ey + 127;
            end else begin
                mant = (q >> 1) & 64'h7FFFFF;
                g    = q[0];
                rb   = 1'b0;
                e    = ex - ey + 126;
            end
            st = (rm != 0) || rb;
            if (g && (st || mant[0])) mant = mant + 1;
            if (mant == 64'h800000) begin
                mant = 0;
                e    = e + 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'h0};
                f = 3'b001;
            end else if (e <= 0) begin
                r = {s, 31'h0};
            end else begin
                r = {s, 8'(e), 23'(mant)};
            end
        end
    endfunction

    // Compare process: one evaluation per falling edge
    always @(negedge clk) begin
        req_t        rq;
        logic [31:0] er;
        logic [2:0]  ef;
        int          lat;
        if (!rst) begin
            if (pend.size() == 0) begin
                check("no_done_when_idle", {31'h0, done}, 32'h0);
            end else if (done) begin
                rq = pend.pop_front();
                model(rq.op_a, rq.op_b, er, ef, lat);
                n_done++;
                check("result", result, er);
                check("fex", {29'h0, fex}, {29'h0, ef});
                check("latency", cyc - rq.acc, lat);
                check("busy_low_at_done", {31'h0, busy}, 32'h0);
                check("done_single_pulse", {31'h0, prev_done}, 32'h0);
                last_result = result;
                last_fex    = fex;
            end else if (cyc >= pend[0].acc) begin
                check("busy_while_pending", {31'h0, busy}, 32'h1);
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [31:0] x, input logic [31:0] y);
        req_t rq;
        @(negedge clk);
        if (!busy) begin
            rq.op_a = x;
            rq.op_b = y;
            rq.acc  = cyc + 1;
            pend.push_back(rq);
        end
        valid = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while ((pend.size() != 0 || busy) && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (pend.size() != 0 || busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: still busy after %0d cycles", limit);
            pend.delete();
        end
    endtask

    task automatic pin(input string name, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic [2:0] ef);
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
        model(x, y, r, f, lat);
        check(name, r, er);
        check(name, {29'h0, f}, {29'h0, ef});
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0: v[30:0] = 31'h0;
            1: v[30:0] = {8'hFF, 23'h0};
            2: v[30:23] = 8'hFF;
            3: v[30:23] = 8'h00;
            4, 5, 6, 7: v[30:23] = 8'($urandom_range(100, 154));
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    initial begin
        int nd;
        rst   = 1'b1;
        valid = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_fex", {29'h0, fex}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;

        // Model pinned against hand-computed values
        pin("pin_6_3",     32'h40C00000, 32'h40400000, 32'h40000000, 3'b000);
        pin("pin_1_3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000);
        pin("pin_m15_05",  32'hBFC00000, 32'h3F000000, 32'hC0400000, 3'b000);
        pin("pin_div0",    32'h3F800000, 32'h80000000, 32'hFF800000, 3'b010);
        pin("pin_0_0",     32'h00000000, 32'h00000000, 32'h7FC00000, 3'b100);
        pin("pin_nan",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100);
        pin("pin_fin_inf", 32'h40000000, 32'h7F800000, 32'h00000000, 3'b000);
        pin("pin_ovf",     32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b001);
        pin("pin_unf",     32'h00800000, 32'h40000000, 32'h00000000, 3'b000);
        pin("pin_10_2",    32'h41200000, 32'h40000000, 32'h40A00000, 3'b000);

        // Directed vectors through the DUT
        issue(32'h40C00000, 32'h40400000); wait_idle(60);
        check("dut_6_3", last_result, 32'h40000000);
        issue(32'h3F800000, 32'h40400000); wait_idle(60);
        check("dut_1_3", last_result, 32'h3EAAAAAB);
        issue(32'hBFC00000, 32'h3F000000); wait_idle(60);
        issue(32'h00000000, 32'h00000000); wait_idle(60);
        issue(32'h7FC00001, 32'h3F800000); wait_idle(60);
        issue(32'h40000000, 32'h7F800000); wait_idle(60);
        issue(32'h7F000000, 32'h3E800000); wait_idle(60);
        check("dut_ovf_fex", {29'h0, last_fex}, 32'h1);
        issue(32'h00800000, 32'h40000000); wait_idle(60);

        // Request while busy is ignored
        nd = n_done;
        issue(32'h40C00000, 32'h40400000);
        repeat (2) @(negedge clk);
        issue(32'h41200000, 32'h40000000);
        wait_idle(60);
        check("busy_ignore_one_done", n_done - nd, 1);
        check("busy_ignore_result", last_result, 32'h40000000);
        issue(32'h41200000, 32'h40000000); wait_idle(60);
        check("fresh_10_2", last_result, 32'h40A00000);

        // Asynchronous reset mid-division
        issue(32'h3F800000, 32'h80000000); wait_idle(60);
        check("pre_reset_fex", {29'h0, last_fex}, 32'h2);
        issue(32'h40C00000, 32'h40400000);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_result", result, 32'h0);
        check("async_rst_fex", {29'h0, fex}, 32'h0);
        check("async_rst_done", {31'h0, done}, 32'h0);
        check("async_rst_busy", {31'h0, busy}, 32'h0);
        pend.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd = n_done;
        repeat (35) @(negedge clk);
        check("no_done_after_reset", n_done - nd, 0);
        issue(32'h3F800000, 32'h40400000); wait_idle(60);
        check("post_reset_1_3", last_result, 32'h3EAAAAAB);

        // Randomised operands, with occasional ignored overlapping requests
        for (int i = 0; i < 150; i++) begin
            issue(rand_op(), rand_op());
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
                issue(rand_op(), rand_op());
            end
            wait_idle(80);
        end

        wait_idle(80);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
